// File: rtl/ssd1306_sink_pkg.sv
// Shared opcodes, addressing-mode and command-FSM enums for the SSD1306 SPI sink.
// The package itself is build-independent; SSD1306_SPI_SINK_PAGE_MODE_EN only affects the top.
package ssd1306_sink_pkg;

  localparam logic [7:0] OP_ADDR_MODE   = 8'h20;
  localparam logic [7:0] OP_COL_ADDR    = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR   = 8'h22;
  localparam logic [7:0] OP_CONTRAST    = 8'h81;
  localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] OP_MUX_RATIO   = 8'hA8;
  localparam logic [7:0] OP_DISPLAY_OFF = 8'hAE;
  localparam logic [7:0] OP_DISPLAY_ON  = 8'hAF;
  localparam logic [7:0] OP_DISP_OFFSET = 8'hD3;
  localparam logic [7:0] OP_CLK_DIV     = 8'hD5;
  localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
  localparam logic [7:0] OP_COM_PINS    = 8'hDA;
  localparam logic [7:0] OP_VCOMH       = 8'hDB;

  typedef enum logic [1:0] {
    MODE_HORIZONTAL = 2'd0,
    MODE_VERTICAL   = 2'd1,
    MODE_PAGE       = 2'd2
  } addr_mode_e;

  typedef enum logic [1:0] {
    CMD_OPCODE = 2'd0,
    CMD_ARG1   = 2'd1,
    CMD_ARG2   = 2'd2
  } cmd_state_e;

  function automatic logic [1:0] arg_count(input logic [7:0] op);
    case (op)
      OP_COL_ADDR, OP_PAGE_ADDR: return 2'd2;
      OP_CONTRAST, OP_ADDR_MODE, OP_CHARGE_PUMP, OP_MUX_RATIO, OP_DISP_OFFSET,
      OP_CLK_DIV, OP_PRECHARGE, OP_COM_PINS, OP_VCOMH: return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ssd1306_spi_sink_shift.sv
// Pin synchronizers, SCLK rising-edge detect and 8-bit MSB-first deserializer.
// Emits a one-cycle byte_valid with the byte and the DC level sampled on its last edge.
module ssd1306_spi_sink_shift #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       csn_i,
  input  logic       dc_i,
  input  logic       sclk_i,
  input  logic       mosi_i,
  output logic [7:0] byte_o,
  output logic       dc_o,
  output logic       byte_valid_o
);

  // pin order inside each stage: {sclk, mosi, dc, csn}
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0] pins_s;
  logic       sclk_prev_q;
  logic [2:0] cnt_q;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte_q;
  logic       dc_q, valid_q;
  logic       sclk_rise;

  assign pins_s    = sync_q[SYNC_STAGES-1];
  assign sclk_rise = pins_s[3] && !sclk_prev_q;
  assign shift_d   = {shift_q[6:0], pins_s[2]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q      <= {SYNC_STAGES{4'b0001}};
      sclk_prev_q <= 1'b0;
      cnt_q       <= 3'd0;
      shift_q     <= 8'h00;
      byte_q      <= 8'h00;
      dc_q        <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], {sclk_i, mosi_i, dc_i, csn_i}};
      sclk_prev_q <= pins_s[3];
      valid_q     <= 1'b0;
      if (pins_s[0]) begin
        cnt_q <= 3'd0;
      end else if (sclk_rise) begin
        shift_q <= shift_d;
        cnt_q   <= cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          byte_q  <= shift_d;
          dc_q    <= pins_s[1];
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign byte_o       = byte_q;
  assign dc_o         = dc_q;
  assign byte_valid_o = valid_q;

endmodule

// File: rtl/ssd1306_spi_sink.sv
// SSD1306 4-wire SPI receive model: command decode plus auto-incrementing framebuffer writes.
// Optional page addressing mode is enabled by defining SSD1306_SPI_SINK_PAGE_MODE_EN.
module ssd1306_spi_sink
  import ssd1306_sink_pkg::*;
#(
  parameter int COLUMNS     = 128,
  parameter int PAGES       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                              clk_in,
  input  logic                              reset_in,
  input  logic                              oled_csn_in,
  input  logic                              oled_dc_in,
  input  logic                              oled_clk_in,
  input  logic                              oled_mosi_in,
  output logic                              fb_we_out,
  output logic [$clog2(COLUMNS*PAGES)-1:0]  fb_addr_out,
  output logic [7:0]                        fb_data_out,
  output logic                              display_on_out,
  output logic [7:0]                        contrast_out,
  output logic                              cmd_stb_out
);

  localparam int CW = $clog2(COLUMNS);
  localparam int PW = $clog2(PAGES);
  localparam int AW = $clog2(COLUMNS*PAGES);

  logic [7:0] rx_byte;
  logic       rx_dc, rx_valid;

  ssd1306_spi_sink_shift #(.SYNC_STAGES(SYNC_STAGES)) u_shift (
    .clk_i       (clk_in),
    .rst_i       (reset_in),
    .csn_i       (oled_csn_in),
    .dc_i        (oled_dc_in),
    .sclk_i      (oled_clk_in),
    .mosi_i      (oled_mosi_in),
    .byte_o      (rx_byte),
    .dc_o        (rx_dc),
    .byte_valid_o(rx_valid)
  );

  cmd_state_e      state_q;
  addr_mode_e      mode_q;
  logic [7:0]      opcode_q;
  logic [CW-1:0]   arg1_q;
  logic [CW-1:0]   col_q, col_start_q, col_end_q, col_d;
  logic [PW-1:0]   page_q, page_start_q, page_end_q, page_d, page_next;
  logic [AW-1:0]   fb_addr_d, fb_addr_q;
  logic [7:0]      fb_data_q, contrast_q;
  logic            fb_we_q, cmd_stb_q, display_on_q;
  logic            mode_ok;

  assign fb_addr_d = AW'(page_q) * AW'(COLUMNS) + AW'(col_q);
  assign page_next = (page_q == page_end_q) ? page_start_q : page_q + PW'(1);

  always_comb begin
    col_d  = col_q + CW'(1);
    page_d = page_q;
    if (mode_q == MODE_PAGE) begin
      col_d = (col_q == CW'(COLUMNS-1)) ? '0 : col_q + CW'(1);
    end else if (col_q == col_end_q) begin
      col_d  = col_start_q;
      page_d = page_next;
    end
  end

  always_comb begin
    mode_ok = (rx_byte[1:0] == 2'd0) || (rx_byte[1:0] == 2'd1);
`ifdef SSD1306_SPI_SINK_PAGE_MODE_EN
    if (rx_byte[1:0] == 2'd2) mode_ok = 1'b1;
`endif
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= CMD_OPCODE;
      mode_q       <= MODE_HORIZONTAL;
      opcode_q     <= 8'h00;
      arg1_q       <= '0;
      col_q        <= '0;
      col_start_q  <= '0;
      col_end_q    <= CW'(COLUMNS-1);
      page_q       <= '0;
      page_start_q <= '0;
      page_end_q   <= PW'(PAGES-1);
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= 8'h00;
      display_on_q <= 1'b0;
      contrast_q   <= 8'h7F;
      cmd_stb_q    <= 1'b0;
    end else begin
      fb_we_q   <= 1'b0;
      cmd_stb_q <= 1'b0;
      if (rx_valid && rx_dc) begin
        fb_we_q   <= 1'b1;
        fb_addr_q <= fb_addr_d;
        fb_data_q <= rx_byte;
        col_q     <= col_d;
        page_q    <= page_d;
      end else if (rx_valid) begin
        case (state_q)
          CMD_OPCODE: begin
            opcode_q <= rx_byte;
            if (arg_count(rx_byte) != 2'd0) begin
              state_q <= CMD_ARG1;
            end else begin
              cmd_stb_q <= 1'b1;
              if (rx_byte == OP_DISPLAY_ON) display_on_q <= 1'b1;
              else if (rx_byte == OP_DISPLAY_OFF) display_on_q <= 1'b0;
`ifdef SSD1306_SPI_SINK_PAGE_MODE_EN
              else if (rx_byte[7:3] == 5'b10110) page_q <= rx_byte[PW-1:0];
              else if (rx_byte[7:4] == 4'h0) col_q <= {col_q[CW-1:4], rx_byte[3:0]};
              else if (rx_byte[7:4] == 4'h1) col_q <= {rx_byte[CW-5:0], col_q[3:0]};
`endif
            end
          end
          CMD_ARG1: begin
            arg1_q <= rx_byte[CW-1:0];
            if (arg_count(opcode_q) == 2'd2) begin
              state_q <= CMD_ARG2;
            end else begin
              state_q   <= CMD_OPCODE;
              cmd_stb_q <= 1'b1;
              if (opcode_q == OP_CONTRAST) contrast_q <= rx_byte;
              else if (opcode_q == OP_ADDR_MODE && mode_ok) mode_q <= addr_mode_e'(rx_byte[1:0]);
            end
          end
          CMD_ARG2: begin
            state_q   <= CMD_OPCODE;
            cmd_stb_q <= 1'b1;
            if (opcode_q == OP_COL_ADDR) begin
              col_start_q <= arg1_q;
              col_end_q   <= rx_byte[CW-1:0];
              col_q       <= arg1_q;
            end else begin
              page_start_q <= arg1_q[PW-1:0];
              page_end_q   <= rx_byte[PW-1:0];
              page_q       <= arg1_q[PW-1:0];
            end
          end
          default: state_q <= CMD_OPCODE;
        endcase
      end
    end
  end

  assign fb_we_out      = fb_we_q;
  assign fb_addr_out    = fb_addr_q;
  assign fb_data_out    = fb_data_q;
  assign display_on_out = display_on_q;
  assign contrast_out   = contrast_q;
  assign cmd_stb_out    = cmd_stb_q;

endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// Bench for ssd1306_spi_sink: directed scenarios then random byte streams,
// each byte checked against a queue-based model of the command set and addressing.
module tb_ssd1306_spi_sink;

  localparam int COLUMNS = 128;
  localparam int PAGES   = 8;
  localparam int AW      = $clog2(COLUMNS*PAGES);

  logic          clk = 1'b0;
  logic          reset_in = 1'b1;
  logic          csn = 1'b1, dc = 1'b0, sclk = 1'b0, mosi = 1'b0;
  logic          fb_we, display_on, cmd_stb;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data, contrast;

  ssd1306_spi_sink #(.COLUMNS(COLUMNS), .PAGES(PAGES), .SYNC_STAGES(2)) dut (
    .clk_in        (clk),
    .reset_in      (reset_in),
    .oled_csn_in   (csn),
    .oled_dc_in    (dc),
    .oled_clk_in   (sclk),
    .oled_mosi_in  (mosi),
    .fb_we_out     (fb_we),
    .fb_addr_out   (fb_addr),
    .fb_data_out   (fb_data),
    .display_on_out(display_on),
    .contrast_out  (contrast),
    .cmd_stb_out   (cmd_stb)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // monitor: only this block writes these
  int we_total = 0, stb_total = 0, last_addr = 0, last_data = 0;
  always @(negedge clk) begin
    if (!reset_in) begin
      if (fb_we) begin
        we_total  <= we_total + 1;
        last_addr <= int'(fb_addr);
        last_data <= int'(fb_data);
      end
      if (cmd_stb) stb_total <= stb_total + 1;
    end
  end
  int we_seen = 0, stb_seen = 0;

  // reference model
  int m_col, m_cs, m_ce, m_page, m_ps, m_pe, m_contrast;
  bit m_disp;
  int cq[$];

  function automatic int nargs(input int op);
    case (op)
      'h21, 'h22: return 2;
      'h81, 'h20, 'h8D, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_col = 0; m_cs = 0; m_ce = COLUMNS-1;
    m_page = 0; m_ps = 0; m_pe = PAGES-1;
    m_contrast = 'h7F; m_disp = 0;
    cq.delete();
  endtask

  task automatic model_byte(input bit d, input int b, output bit exp_we, output int exp_addr,
                            output bit exp_stb);
    exp_we = 0; exp_addr = 0; exp_stb = 0;
    if (d) begin
      exp_we   = 1;
      exp_addr = m_page * COLUMNS + m_col;
      if (m_col == m_ce) begin
        m_col  = m_cs;
        m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % PAGES;
      end else begin
        m_col = (m_col + 1) % COLUMNS;
      end
    end else begin
      cq.push_back(b);
      if (cq.size() == nargs(cq[0]) + 1) begin
        exp_stb = 1;
        case (cq[0])
          'h21: begin m_cs = cq[1] % COLUMNS; m_ce = cq[2] % COLUMNS; m_col = m_cs; end
          'h22: begin m_ps = cq[1] % PAGES; m_pe = cq[2] % PAGES; m_page = m_ps; end
          'h81: m_contrast = cq[1];
          'hAF: m_disp = 1;
          'hAE: m_disp = 0;
          default: ;
        endcase
        cq.delete();
      end
    end
  endtask

  task automatic spi_bits(input bit d, input logic [7:0] b, input int nbits);
    csn = 1'b0;
    dc  = d;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input bit d, input logic [7:0] b);
    bit e_we, e_stb;
    int e_addr;
    model_byte(d, int'(b), e_we, e_addr, e_stb);
    spi_bits(d, b, 8);
    repeat (10) @(negedge clk);
    check("we_count", we_total - we_seen, e_we ? 1 : 0);
    if (e_we) begin
      check("fb_addr", last_addr, e_addr);
      check("fb_data", last_data, int'(b));
    end
    check("stb_count", stb_total - stb_seen, e_stb ? 1 : 0);
    check("display_on", display_on, m_disp);
    check("contrast", contrast, m_contrast);
    we_seen  = we_total;
    stb_seen = stb_total;
  endtask

  task automatic async_reset_check();
    #3;
    reset_in = 1'b1;
    #1;
    check("rst_we", fb_we, 0);
    check("rst_addr", fb_addr, 0);
    check("rst_data", fb_data, 0);
    check("rst_disp", display_on, 0);
    check("rst_contrast", contrast, 'h7F);
    check("rst_stb", cmd_stb, 0);
    model_reset();
    csn = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    reset_in = 1'b0;
    repeat (3) @(negedge clk);
    we_seen  = we_total;
    stb_seen = stb_total;
  endtask

  int cmd_list[14] = '{'h21, 'h22, 'h81, 'h20, 'hAF, 'hAE, 'h8D, 'hA8, 'hD3, 'hDA, 'hE3, 'hA1, 'hB2, 'h05};

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("init_contrast", contrast, 'h7F);
    check("init_disp", display_on, 0);
    check("init_addr", fb_addr, 0);
    reset_in = 1'b0;
    repeat (3) @(negedge clk);

    xfer(1, 8'hA5);
    xfer(1, 8'h3C);

    xfer(0, 8'h21); xfer(0, 8'h10); xfer(0, 8'h11);
    xfer(0, 8'h22); xfer(0, 8'h02); xfer(0, 8'h03);
    for (int i = 0; i < 5; i++) xfer(1, 8'(8'h50 + i));

    xfer(0, 8'hAF);
    xfer(0, 8'h81); xfer(0, 8'h40);

    spi_bits(1, 8'h00, 5);
    csn = 1'b1;
    repeat (8) @(negedge clk);
    check("partial_no_we", we_total - we_seen, 0);
    xfer(1, 8'hFF);

    xfer(0, 8'h81); xfer(1, 8'h11); xfer(0, 8'h22);

    xfer(0, 8'h81);
    spi_bits(0, 8'h99, 4);
    async_reset_check();
    xfer(0, 8'hAF);

    spi_bits(1, 8'hC3, 3);
    async_reset_check();
    xfer(1, 8'h55);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(3) == 0) begin
        csn = 1'b1;
        repeat ($urandom_range(6, 2)) @(negedge clk);
      end
      if ($urandom_range(1) == 1) xfer(1, 8'($urandom));
      else if (cq.size() == 0) xfer(0, 8'(cmd_list[$urandom_range(13)]));
      else xfer(0, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ssd1306_spi_sink.md
Name: ssd1306_spi_sink

Overview:
- Receive-side model of the SSD1306 4-wire SPI interface. Consumes the CS#/DC/SCLK/MOSI pins that our OLED driver produces.
- Decodes the command subset our driver issues: addressing, display on/off, contrast, and parameterised setup commands.
- Turns data bytes into framebuffer write strobes with SSD1306 auto-increment addressing.
- Used as a bench display model and as an on-FPGA loopback target for driver self-test.

Parameters:
- COLUMNS, 128, framebuffer columns; column pointer width is $clog2(COLUMNS).
- PAGES, 8, framebuffer pages of 8 rows each; page pointer width is $clog2(PAGES).
- SYNC_STAGES, 2, flip-flop stages on each asynchronous pin input.

Ports:
- clk_in  in  1  system clock; must be at least 4x the SCLK frequency.
- reset_in  in  1  asynchronous, active-high reset.
- oled_csn_in  in  1  chip select, active low.
- oled_dc_in  in  1  1 = data byte, 0 = command byte.
- oled_clk_in  in  1  SPI clock; MOSI is sampled on its rising edge (mode 0).
- oled_mosi_in  in  1  serial data, MSB first.
- fb_we_out  out  1  one-cycle framebuffer write strobe.
- fb_addr_out  out  $clog2(COLUMNS*PAGES)  write address = page*COLUMNS + col.
- fb_data_out  out  8  data byte; bit0 is the top row of the page.
- display_on_out  out  1  set by 0xAF, cleared by 0xAE.
- contrast_out  out  8  last 0x81 argument.
- cmd_stb_out  out  1  one-cycle pulse per completed command, including its arguments.

Behaviour:
- Reset values (asynchronous):
  - fb_we_out = 0, fb_addr_out = 0, fb_data_out = 0, display_on_out = 0, contrast_out = 0x7F, cmd_stb_out = 0.
  - col = col_start = 0, col_end = COLUMNS-1; page = page_start = 0, page_end = PAGES-1.
  - Addressing mode = horizontal; command FSM = CMD_OPCODE; bit count = 0.
- Input sync: all four pins pass through SYNC_STAGES flops. An SCLK rising edge is detected as sync = 1 while the previous sync = 0.
- Shifting: on each detected edge with CS# low, shift MOSI into the LSB and increment a 3-bit count.
- Byte completion: when the 8th bit is shifted in, the byte plus the synchronized DC at that edge form byte_valid for one cycle.
- CS# high clears the bit count and discards any partial byte. Command FSM state and pointers are kept.
- Data byte (DC = 1), one cycle after byte_valid:
  - fb_we_out = 1, fb_addr_out = page*COLUMNS + col, fb_data_out = byte.
  - Pointers advance in that same cycle.
  - Horizontal mode: if col == col_end then col <= col_start and the page advances; otherwise col++.
  - Page advance: if page == page_end then page <= page_start; otherwise page++.
  - Data bytes never change the command FSM; they may arrive between command arguments.
- Command FSM states: CMD_OPCODE, CMD_ARG1, CMD_ARG2.
  - In CMD_OPCODE:
    - 0x21 / 0x22 go to CMD_ARG1 (two arguments).
    - 0x81, 0x20, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB go to CMD_ARG1 (one argument).
    - 0xAE / 0xAF take effect immediately.
    - Any other opcode is ignored as a single-byte command.
  - 0x21 A B: col_start <= A, col_end <= B, col <= A. Arguments are masked to the column width.
  - 0x22 A B: page_start <= A, page_end <= B, page <= A. Arguments are masked to the page width.
  - 0x81 X: contrast_out <= X.
  - 0x20 M: mode <= M[1:0]. Unsupported mode values are ignored.
  - All other one-argument commands: the argument is consumed and discarded.
  - cmd_stb_out pulses one cycle after the final byte of a command is received, including single-byte commands.
- Latency: fb_we_out and cmd_stb_out assert exactly 1 clk_in cycle after byte_valid.

Optional Feature:
- Macro: SSD1306_SPI_SINK_PAGE_MODE_EN.
- Defined:
  - 0x20 with argument 0x02 selects page mode.
  - 0xB0+n sets page <= n.
  - 0x00-0x0F sets the low nibble of col; 0x10-0x1F sets the high nibble of col.
  - In page mode, col wraps from COLUMNS-1 to 0 and page does not change.
- Undefined:
  - Page mode is rejected, so mode stays horizontal.
  - 0xB0-0xB7 and 0x00-0x1F are ignored single-byte commands (cmd_stb_out still pulses).

Decomposition:
- Package ssd1306_sink_pkg holds:
  - Opcode localparams.
  - Addressing mode enum (HORIZONTAL = 0, VERTICAL = 1 treated as horizontal, PAGE = 2).
  - Command FSM state enum.
  - Function returning argument count per opcode.
- Sub-module ssd1306_spi_sink_shift: synchronizers, SCLK edge detect, shift register and bit count. Outputs byte and dc with a byte_valid pulse.

Test Plan:
- After reset, send data 0xA5 with DC = 1 → fb_we_out with addr 0, data 0xA5; a second byte 0x3C → addr 1.
- Send 0x21 0x10 0x11 and 0x22 0x02 0x03, then 5 data bytes → addresses 2*128+16, +17, 3*128+16, +17, then wrap to 2*128+16.
- Send 0xAF, then 0x81 0x40 → display_on_out = 1, contrast_out = 0x40, two cmd_stb_out pulses; no fb_we_out.
- Raise CS# after 5 bits, then send a full data byte 0xFF → a single write of 0xFF; the partial byte never appears.
- Send 0x81, then data 0x11 (DC = 1), then command byte 0x22 → 0x11 is written to the framebuffer and contrast_out = 0x22.
- Assert reset_in mid-byte and mid-argument → outputs return to reset values asynchronously; the next byte is decoded as an opcode.
